// File: rtl/grf_write_arbiter_if.sv
// GRF write-port arbitration bundle: two requesters, scoreboard claim, and the registered
// GRF write port with scoreboard state.
interface grf_write_arbiter_if;
    logic        hold;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic [31:0] a_pc;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [31:0] b_pc;
    logic        claim_valid;
    logic [4:0]  claim_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;
    logic [31:0] pending;
    logic        last_grant;

    modport master (
        output hold, a_valid, a_addr, a_data, a_pc, b_valid, b_addr, b_data, b_pc,
               claim_valid, claim_addr,
        input  a_ready, b_ready, wr_en, wr_addr, wr_data, wr_pc, pending, last_grant
    );

    modport slave (
        input  hold, a_valid, a_addr, a_data, a_pc, b_valid, b_addr, b_data, b_pc,
               claim_valid, claim_addr,
        output a_ready, b_ready, wr_en, wr_addr, wr_data, wr_pc, pending, last_grant
    );
endinterface

// File: rtl/grf_write_arbiter.sv
// Round-robin arbiter sharing the GRF write port between writeback (A) and the multi-cycle
// unit (B), with a registered write stage and a per-register pending scoreboard for B.
module grf_write_arbiter (
    input logic                i_clk,
    input logic                i_reset,
    grf_write_arbiter_if.slave bus
);

    logic        w_a_grant;
    logic        w_b_grant;
    logic [31:0] w_pending_d;

    logic        r_wr_en;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic [31:0] r_wr_pc;
    logic [31:0] r_pending;
    logic        r_last_grant;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        w_a_grant = 1'b0;
        w_b_grant = 1'b0;
        if (!bus.hold) begin
            if (bus.a_valid && bus.b_valid) begin
                w_a_grant = r_last_grant;
                w_b_grant = !r_last_grant;
            end else begin
                w_a_grant = bus.a_valid;
                w_b_grant = bus.b_valid;
            end
        end
    end

    // Claim is applied after the clear so a same-cycle claim wins.
    always_comb begin
        w_pending_d = r_pending;
        if (w_b_grant) begin
            w_pending_d[bus.b_addr] = 1'b0;
        end
        if (bus.claim_valid) begin
            w_pending_d[bus.claim_addr] = 1'b1;
        end
        w_pending_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 5'd0;
            r_wr_data    <= 32'd0;
            r_wr_pc      <= 32'd0;
            r_pending    <= 32'd0;
            r_last_grant <= 1'b1;
        end else begin
            r_wr_en   <= 1'b0;
            r_pending <= w_pending_d;
            if (w_a_grant) begin
                r_wr_en      <= |bus.a_addr;
                r_wr_addr    <= bus.a_addr;
                r_wr_data    <= bus.a_data;
                r_wr_pc      <= bus.a_pc;
                r_last_grant <= 1'b0;
            end else if (w_b_grant) begin
                r_wr_en      <= |bus.b_addr;
                r_wr_addr    <= bus.b_addr;
                r_wr_data    <= bus.b_data;
                r_wr_pc      <= bus.b_pc;
                r_last_grant <= 1'b1;
            end
        end
    end

    assign bus.a_ready    = w_a_grant;
    assign bus.b_ready    = w_b_grant;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.wr_pc      = r_wr_pc;
    assign bus.pending    = r_pending;
    assign bus.last_grant = r_last_grant;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Scoreboard bench for grf_write_arbiter: directed scenarios then randomized traffic checked
// against a behavioural model of the arbitration and scoreboard rules.
module tb_grf_write_arbiter;

    logic clk;
    logic reset;

    grf_write_arbiter_if bus ();

    grf_write_arbiter dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] pend;
        logic        last;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: who won last (0 = A, 1 = B), outstanding B results, held write-port fields.
    logic        m_last;
    logic        m_pend [32];
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_pc;
    logic        a_tk;
    logic        b_tk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_pc   = '0;
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic set_in(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                          input logic [31:0] ap, input logic bv, input logic [4:0] ba,
                          input logic [31:0] bd, input logic [31:0] bp, input logic cv,
                          input logic [4:0] ca, input logic h);
        bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad; bus.a_pc = ap;
        bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd; bus.b_pc = bp;
        bus.claim_valid = cv; bus.claim_addr = ca; bus.hold = h;
    endtask

    // Called at a falling edge with inputs applied: checks readies, predicts the next cycle.
    task automatic step();
        logic ea, eb, ga, gb;
        exp_t e;
        #1;
        ea = bus.a_valid && !bus.hold;
        eb = bus.b_valid && !bus.hold;
        if (ea && eb) begin
            ga = (m_last == 1'b1);
            gb = !ga;
        end else begin
            ga = ea;
            gb = eb;
        end
        chk("a_ready", 32'(bus.a_ready), 32'(ga));
        chk("b_ready", 32'(bus.b_ready), 32'(gb));
        e.en = 1'b0;
        if (ga) begin
            m_addr = bus.a_addr; m_data = bus.a_data; m_pc = bus.a_pc;
            e.en = (bus.a_addr != 0);
            m_last = 1'b0;
        end else if (gb) begin
            m_addr = bus.b_addr; m_data = bus.b_data; m_pc = bus.b_pc;
            e.en = (bus.b_addr != 0);
            m_last = 1'b1;
            m_pend[bus.b_addr] = 1'b0;
        end
        if (bus.claim_valid && bus.claim_addr != 0) m_pend[bus.claim_addr] = 1'b1;
        e.addr = m_addr; e.data = m_data; e.pc = m_pc;
        e.pend = pend_vec();
        e.last = m_last;
        q.push_back(e);
        a_tk = ga;
        b_tk = gb;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset && q.size() > 0) begin
            mon_e = q.pop_front();
            chk("wr_en",      32'(bus.wr_en),      32'(mon_e.en));
            chk("wr_addr",    32'(bus.wr_addr),    32'(mon_e.addr));
            chk("wr_data",    bus.wr_data,         mon_e.data);
            chk("wr_pc",      bus.wr_pc,           mon_e.pc);
            chk("pending",    bus.pending,         mon_e.pend);
            chk("last_grant", 32'(bus.last_grant), 32'(mon_e.last));
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, " wr_en"},      32'(bus.wr_en),      32'd0);
        chk({tag, " wr_addr"},    32'(bus.wr_addr),    32'd0);
        chk({tag, " wr_data"},    bus.wr_data,         32'd0);
        chk({tag, " wr_pc"},      bus.wr_pc,           32'd0);
        chk({tag, " pending"},    bus.pending,         32'd0);
        chk({tag, " last_grant"}, 32'(bus.last_grant), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;

        // Single A write.
        set_in(1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // Continuous contention: strict alternation.
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 32'h11, 32'h100, 1, 2, 32'h22, 32'h200, 0, 0, 0); step();
        end

        // Scoreboard claim, clear, and same-cycle claim+clear.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0); step();
        set_in(0, 0, 0, 0, 1, 7, 32'hCAFE, 32'h400, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0); step();
        set_in(0, 0, 0, 0, 1, 7, 32'hBEEF, 32'h404, 1, 7, 0); step();

        // Address 0 write and claim.
        set_in(1, 0, 32'hFFFF_FFFF, 32'h500, 0, 0, 0, 0, 1, 0, 0); step();

        // Hold with both valid, then release.
        set_in(1, 3, 32'h33, 32'h600, 1, 4, 32'h44, 32'h700, 0, 0, 1); step();
        set_in(1, 3, 32'h33, 32'h600, 1, 4, 32'h44, 32'h700, 0, 0, 0); step();
        step();

        // Build pending = 0xF00 (clear 7) with a write in flight, then reset mid-cycle.
        set_in(0, 0, 0, 0, 1, 7, 32'h77, 32'h800, 1, 8, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0); step();
        set_in(1, 3, 32'h9999, 32'h900, 0, 0, 0, 0, 1, 11, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre-reset wr_en", 32'(bus.wr_en), 32'd1);
        chk("pre-reset pending", bus.pending, 32'h0000_0F00);
        #2 reset = 1'b1;
        #1 chk_reset_state("async reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Randomized traffic; requesters hold requests until accepted.
        a_tk = 1'b1;
        b_tk = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (!bus.a_valid || a_tk) begin
                bus.a_valid = ($urandom_range(9) < 6);
                bus.a_addr  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
                bus.a_data  = $urandom;
                bus.a_pc    = $urandom;
            end
            if (!bus.b_valid || b_tk) begin
                bus.b_valid = ($urandom_range(9) < 6);
                bus.b_addr  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
                bus.b_data  = $urandom;
                bus.b_pc    = $urandom;
            end
            bus.claim_valid = ($urandom_range(3) == 0);
            bus.claim_addr  = 5'($urandom);
            bus.hold        = ($urandom_range(9) == 0);
            step();
        end

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        chk("queue drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
